// File: rtl/alu_operand_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_operand_stage_if
// Brief    : Decode, forwarding and ALU-operand bundle for alu_operand_stage.
// Revision : 1.0
// ============================================================================
interface alu_operand_stage_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int OPCODE_LENGTH  = 4,
    parameter int REG_ADDR_WIDTH = 5
);
    logic                      id_valid;
    logic [REG_ADDR_WIDTH-1:0] id_rs1;
    logic [REG_ADDR_WIDTH-1:0] id_rs2;
    logic [REG_ADDR_WIDTH-1:0] id_rd;
    logic [DATA_WIDTH-1:0]     id_rs1_data;
    logic [DATA_WIDTH-1:0]     id_rs2_data;
    logic [DATA_WIDTH-1:0]     id_imm;
    logic                      id_alu_src;
    logic [OPCODE_LENGTH-1:0]  id_alu_op;
    logic                      id_reg_write;
    logic                      stall;
    logic                      flush;
    logic                      mem_reg_write;
    logic [REG_ADDR_WIDTH-1:0] mem_rd;
    logic [DATA_WIDTH-1:0]     mem_result;
    logic                      wb_reg_write;
    logic [REG_ADDR_WIDTH-1:0] wb_rd;
    logic [DATA_WIDTH-1:0]     wb_result;
    logic [DATA_WIDTH-1:0]     SrcA;
    logic [DATA_WIDTH-1:0]     SrcB;
    logic [OPCODE_LENGTH-1:0]  Operation;
    logic                      ex_valid;
    logic [REG_ADDR_WIDTH-1:0] ex_rd;
    logic                      ex_reg_write;
    logic [DATA_WIDTH-1:0]     ex_store_data;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data,
               id_imm, id_alu_src, id_alu_op, id_reg_write, stall, flush,
               mem_reg_write, mem_rd, mem_result,
               wb_reg_write, wb_rd, wb_result,
        input  SrcA, SrcB, Operation, ex_valid, ex_rd, ex_reg_write,
               ex_store_data
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data,
               id_imm, id_alu_src, id_alu_op, id_reg_write, stall, flush,
               mem_reg_write, mem_rd, mem_result,
               wb_reg_write, wb_rd, wb_result,
        output SrcA, SrcB, Operation, ex_valid, ex_rd, ex_reg_write,
               ex_store_data
    );
endinterface
`default_nettype wire

// File: rtl/alu_operand_stage.sv
`default_nettype none
// ============================================================================
// Module   : alu_operand_stage
// Brief    : ID/EX register with MEM/WB operand forwarding and SrcB mux.
// Revision : 1.0
// ============================================================================
module alu_operand_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int OPCODE_LENGTH  = 4,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  wire logic         clk,
    input  wire logic         reset,
    alu_operand_stage_if.slave bus
);
    localparam logic [REG_ADDR_WIDTH-1:0] c_X0 = '0;

    logic                      r_valid;
    logic [REG_ADDR_WIDTH-1:0] r_rs1;
    logic [REG_ADDR_WIDTH-1:0] r_rs2;
    logic [REG_ADDR_WIDTH-1:0] r_rd;
    logic [DATA_WIDTH-1:0]     r_rs1_data;
    logic [DATA_WIDTH-1:0]     r_rs2_data;
    logic [DATA_WIDTH-1:0]     r_imm;
    logic                      r_alu_src;
    logic [OPCODE_LENGTH-1:0]  r_alu_op;
    logic                      r_reg_write;

    logic [DATA_WIDTH-1:0]     w_fwd_a;
    logic [DATA_WIDTH-1:0]     w_fwd_b;
    logic                      w_bubble;

    // MEM is the younger producer, so it wins over WB; x0 is hard-wired zero.
    always_comb begin
        w_fwd_a = r_rs1_data;
        if (bus.mem_reg_write && (bus.mem_rd == r_rs1) && (r_rs1 != c_X0))
            w_fwd_a = bus.mem_result;
        else if (bus.wb_reg_write && (bus.wb_rd == r_rs1) && (r_rs1 != c_X0))
            w_fwd_a = bus.wb_result;
    end

    always_comb begin
        w_fwd_b = r_rs2_data;
        if (bus.mem_reg_write && (bus.mem_rd == r_rs2) && (r_rs2 != c_X0))
            w_fwd_b = bus.mem_result;
        else if (bus.wb_reg_write && (bus.wb_rd == r_rs2) && (r_rs2 != c_X0))
            w_fwd_b = bus.wb_result;
    end

    assign w_bubble = bus.flush || (!bus.stall && !bus.id_valid);

    always_ff @(posedge clk or posedge reset) begin
        if (reset || w_bubble) begin
            r_valid     <= 1'b0;
            r_rs1       <= '0;
            r_rs2       <= '0;
            r_rd        <= '0;
            r_rs1_data  <= '0;
            r_rs2_data  <= '0;
            r_imm       <= '0;
            r_alu_src   <= 1'b0;
            r_alu_op    <= '0;
            r_reg_write <= 1'b0;
        end else if (bus.stall) begin
            // Refresh held operands so a WB value retiring mid-stall is kept.
            r_rs1_data  <= w_fwd_a;
            r_rs2_data  <= w_fwd_b;
        end else begin
            r_valid     <= 1'b1;
            r_rs1       <= bus.id_rs1;
            r_rs2       <= bus.id_rs2;
            r_rd        <= bus.id_rd;
            r_rs1_data  <= bus.id_rs1_data;
            r_rs2_data  <= bus.id_rs2_data;
            r_imm       <= bus.id_imm;
            r_alu_src   <= bus.id_alu_src;
            r_alu_op    <= bus.id_alu_op;
            r_reg_write <= bus.id_reg_write;
        end
    end

    assign bus.SrcA          = r_valid ? w_fwd_a : '0;
    assign bus.SrcB          = r_valid ? (r_alu_src ? r_imm : w_fwd_b) : '0;
    assign bus.ex_store_data = r_valid ? w_fwd_b : '0;
    assign bus.Operation     = r_valid ? r_alu_op : '0;
    assign bus.ex_valid      = r_valid;
    assign bus.ex_rd         = r_rd;
    assign bus.ex_reg_write  = r_valid & r_reg_write;

endmodule
`default_nettype wire

// File: tb/tb_alu_operand_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_operand_stage
// Brief    : Directed and randomized checks of alu_operand_stage.
// Revision : 1.0
// ============================================================================
module tb_alu_operand_stage;
    localparam int DW = 32;
    localparam int OW = 4;
    localparam int AW = 5;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    alu_operand_stage_if #(.DATA_WIDTH(DW), .OPCODE_LENGTH(OW), .REG_ADDR_WIDTH(AW)) bus ();

    alu_operand_stage #(.DATA_WIDTH(DW), .OPCODE_LENGTH(OW), .REG_ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    // Reference: the instruction currently sitting in EX.
    typedef struct {
        bit            valid;
        bit [AW-1:0]   rs1, rs2, rd;
        bit [DW-1:0]   d1, d2, imm;
        bit            src;
        bit [OW-1:0]   op;
        bit            rw;
    } ex_t;

    ex_t m;

    function automatic ex_t empty_ex();
        ex_t e;
        e.valid = 0; e.rs1 = 0; e.rs2 = 0; e.rd = 0; e.d1 = 0; e.d2 = 0;
        e.imm = 0; e.src = 0; e.op = 0; e.rw = 0;
        return e;
    endfunction

    // Value of register r as seen now: newest in-flight result, else the held value.
    function automatic logic [DW-1:0] reg_value(logic [AW-1:0] r, logic [DW-1:0] held);
        if (r == 0) return held;
        if (bus.mem_reg_write && bus.mem_rd == r) return bus.mem_result;
        if (bus.wb_reg_write && bus.wb_rd == r) return bus.wb_result;
        return held;
    endfunction

    function automatic logic [DW-1:0] exp_srca();
        return m.valid ? reg_value(m.rs1, m.d1) : '0;
    endfunction
    function automatic logic [DW-1:0] exp_store();
        return m.valid ? reg_value(m.rs2, m.d2) : '0;
    endfunction
    function automatic logic [DW-1:0] exp_srcb();
        if (!m.valid) return '0;
        return m.src ? m.imm : reg_value(m.rs2, m.d2);
    endfunction

    task automatic tick();
        ex_t nx;
        nx = m;
        if (bus.flush) nx = empty_ex();
        else if (bus.stall) begin
            nx.d1 = reg_value(m.rs1, m.d1);
            nx.d2 = reg_value(m.rs2, m.d2);
        end else if (!bus.id_valid) nx = empty_ex();
        else begin
            nx.valid = 1; nx.rs1 = bus.id_rs1; nx.rs2 = bus.id_rs2; nx.rd = bus.id_rd;
            nx.d1 = bus.id_rs1_data; nx.d2 = bus.id_rs2_data; nx.imm = bus.id_imm;
            nx.src = bus.id_alu_src; nx.op = bus.id_alu_op; nx.rw = bus.id_reg_write;
        end
        @(posedge clk);
        #1;
        m = nx;
    endtask

    task automatic idle_inputs();
        bus.id_valid = 0; bus.id_rs1 = 0; bus.id_rs2 = 0; bus.id_rd = 0;
        bus.id_rs1_data = 0; bus.id_rs2_data = 0; bus.id_imm = 0;
        bus.id_alu_src = 0; bus.id_alu_op = 0; bus.id_reg_write = 0;
        bus.stall = 0; bus.flush = 0;
        bus.mem_reg_write = 0; bus.mem_rd = 0; bus.mem_result = 0;
        bus.wb_reg_write = 0; bus.wb_rd = 0; bus.wb_result = 0;
    endtask

    task automatic load_id(input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                           input logic [DW-1:0] d1, input logic [DW-1:0] d2,
                           input logic src, input logic [DW-1:0] imm,
                           input logic [OW-1:0] op);
        bus.id_valid = 1; bus.id_rs1 = rs1; bus.id_rs2 = rs2; bus.id_rd = 5'd10;
        bus.id_rs1_data = d1; bus.id_rs2_data = d2; bus.id_imm = imm;
        bus.id_alu_src = src; bus.id_alu_op = op; bus.id_reg_write = 1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1; #12; rst = 0;
        m = empty_ex();
        load_id(5'd1, 5'd2, 32'h77, 32'h66, 0, 0, 4'h3);
        tick();
        #2 rst = 1;
        m = empty_ex();
        #1;
        n_checks++;
        if ({bus.SrcA, bus.SrcB, bus.Operation, bus.ex_valid, bus.ex_rd,
             bus.ex_reg_write, bus.ex_store_data} !== '0)
            begin n_errors++; $display("FAIL reset_async: SrcA=%h SrcB=%h op=%h valid=%b rd=%0d rw=%b st=%h expected all 0",
                bus.SrcA, bus.SrcB, bus.Operation, bus.ex_valid, bus.ex_rd, bus.ex_reg_write, bus.ex_store_data); end
        @(negedge clk); rst = 0;
        load_id(5'd1, 5'd2, 32'd5, 32'd3, 0, 0, 4'b0001);
        tick();
        n_checks++;
        if (bus.SrcA !== 32'd5 || bus.SrcB !== 32'd3 || bus.Operation !== 4'b0001)
            begin n_errors++; $display("FAIL reset_first_op: SrcA=%h SrcB=%h op=%h expected 5 3 1", bus.SrcA, bus.SrcB, bus.Operation); end
    endtask

    task automatic test_forward_priority();
        load_id(5'd7, 5'd8, 32'h11, 32'h22, 0, 0, 4'h2);
        tick();
        bus.mem_reg_write = 1; bus.mem_rd = 7; bus.mem_result = 32'hAA;
        bus.wb_reg_write = 1;  bus.wb_rd = 7;  bus.wb_result = 32'hBB;
        #1;
        n_checks++;
        if (bus.SrcA !== 32'hAA) begin n_errors++; $display("FAIL fwd_mem_priority: SrcA=%h expected 000000aa", bus.SrcA); end
        bus.mem_reg_write = 0;
        #1;
        n_checks++;
        if (bus.SrcA !== 32'hBB) begin n_errors++; $display("FAIL fwd_wb: SrcA=%h expected 000000bb", bus.SrcA); end
        n_checks++;
        if (bus.SrcB !== 32'h22) begin n_errors++; $display("FAIL fwd_no_match_b: SrcB=%h expected 00000022", bus.SrcB); end
        idle_inputs();
    endtask

    task automatic test_x0_guard();
        load_id(5'd3, 5'd0, 32'h1, 32'h0, 0, 0, 4'h0);
        tick();
        bus.mem_reg_write = 1; bus.mem_rd = 0; bus.mem_result = 32'h55;
        bus.wb_reg_write = 1;  bus.wb_rd = 0;  bus.wb_result = 32'h66;
        #1;
        n_checks++;
        if (bus.SrcB !== 32'h0 || bus.ex_store_data !== 32'h0)
            begin n_errors++; $display("FAIL x0_guard: SrcB=%h store=%h expected 0 0", bus.SrcB, bus.ex_store_data); end
        idle_inputs();
    endtask

    task automatic test_imm_select();
        load_id(5'd1, 5'd3, 32'h1, 32'h2, 1, 32'hFFFF_FFFC, 4'h4);
        tick();
        bus.mem_reg_write = 1; bus.mem_rd = 3; bus.mem_result = 32'd9;
        #1;
        n_checks++;
        if (bus.SrcB !== 32'hFFFF_FFFC) begin n_errors++; $display("FAIL imm_srcb: SrcB=%h expected fffffffc", bus.SrcB); end
        n_checks++;
        if (bus.ex_store_data !== 32'd9) begin n_errors++; $display("FAIL imm_store: store=%h expected 00000009", bus.ex_store_data); end
        idle_inputs();
    endtask

    task automatic test_stall_retention();
        load_id(5'd4, 5'd5, 32'h10, 32'h20, 0, 0, 4'h6);
        tick();
        bus.stall = 1;
        bus.wb_reg_write = 1; bus.wb_rd = 4; bus.wb_result = 32'h1234;
        load_id(5'd9, 5'd9, 32'hDEAD, 32'hBEEF, 1, 32'h5, 4'hF);
        #1;
        n_checks++;
        if (bus.SrcA !== 32'h1234) begin n_errors++; $display("FAIL stall_c1: SrcA=%h expected 00001234", bus.SrcA); end
        tick();
        bus.wb_rd = 9; bus.wb_result = 32'h9999;
        bus.id_rs1_data = 32'hCAFE;
        #1;
        n_checks++;
        if (bus.SrcA !== 32'h1234) begin n_errors++; $display("FAIL stall_c2: SrcA=%h expected 00001234", bus.SrcA); end
        tick();
        n_checks++;
        if (bus.SrcA !== 32'h1234 || bus.Operation !== 4'h6 || bus.SrcB !== 32'h20)
            begin n_errors++; $display("FAIL stall_c3: SrcA=%h op=%h SrcB=%h expected 1234 6 20", bus.SrcA, bus.Operation, bus.SrcB); end
        tick();
        bus.stall = 0; bus.wb_reg_write = 0;
        tick();
        n_checks++;
        if (bus.Operation !== 4'hF || bus.SrcB !== 32'h5 || bus.SrcA !== 32'hCAFE)
            begin n_errors++; $display("FAIL stall_release: op=%h SrcB=%h SrcA=%h expected f 5 cafe", bus.Operation, bus.SrcB, bus.SrcA); end
        idle_inputs();
    endtask

    task automatic test_flush();
        load_id(5'd1, 5'd2, 32'h3, 32'h4, 0, 0, 4'h7);
        tick();
        bus.stall = 1; bus.flush = 1;
        tick();
        n_checks++;
        if (bus.ex_valid !== 1'b0 || bus.ex_reg_write !== 1'b0 || bus.Operation !== 4'h0 ||
            bus.SrcA !== '0 || bus.SrcB !== '0)
            begin n_errors++; $display("FAIL flush: valid=%b rw=%b op=%h SrcA=%h SrcB=%h expected all 0",
                bus.ex_valid, bus.ex_reg_write, bus.Operation, bus.SrcA, bus.SrcB); end
        idle_inputs();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            bus.id_valid     = ($urandom_range(0, 9) < 8);
            bus.id_rs1       = AW'($urandom_range(0, 3));
            bus.id_rs2       = AW'($urandom_range(0, 3));
            bus.id_rd        = AW'($urandom);
            bus.id_rs1_data  = $urandom;
            bus.id_rs2_data  = $urandom;
            bus.id_imm       = $urandom;
            bus.id_alu_src   = 1'($urandom);
            bus.id_alu_op    = OW'($urandom);
            bus.id_reg_write = 1'($urandom);
            bus.stall        = ($urandom_range(0, 3) == 0);
            bus.flush        = ($urandom_range(0, 9) == 0);
            bus.mem_reg_write = 1'($urandom); bus.mem_rd = AW'($urandom_range(0, 3)); bus.mem_result = $urandom;
            bus.wb_reg_write  = 1'($urandom); bus.wb_rd  = AW'($urandom_range(0, 3)); bus.wb_result  = $urandom;
            tick();
            n_checks++;
            if (bus.SrcA !== exp_srca() || bus.SrcB !== exp_srcb() || bus.ex_store_data !== exp_store() ||
                bus.Operation !== (m.valid ? m.op : 4'h0) || bus.ex_valid !== m.valid ||
                bus.ex_rd !== m.rd || bus.ex_reg_write !== (m.valid & m.rw))
                begin n_errors++; $display("FAIL random_%0d: SrcA=%h/%h SrcB=%h/%h st=%h/%h op=%h v=%b rd=%0d rw=%b (got/exp; exp op=%h v=%b rd=%0d rw=%b)",
                    i, bus.SrcA, exp_srca(), bus.SrcB, exp_srcb(), bus.ex_store_data, exp_store(),
                    bus.Operation, bus.ex_valid, bus.ex_rd, bus.ex_reg_write,
                    m.valid ? m.op : 4'h0, m.valid, m.rd, m.valid & m.rw); end
        end
        idle_inputs();
    endtask

    initial begin
        m = empty_ex();
        test_reset();
        test_forward_priority();
        test_x0_guard();
        test_imm_select();
        test_stall_retention();
        test_flush();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/alu_operand_stage.md
# alu_operand_stage

ID/EX pipeline stage that feeds the ALU its `SrcA`, `SrcB` and `Operation` inputs. It does three things:
- registers decoded instruction fields from the decode stage;
- resolves data hazards by forwarding results from the MEM and WB stages;
- selects between the register operand and the immediate for `SrcB`.

It supports stall (hold the instruction) and flush (insert a bubble). While stalled, it keeps forwarded operands coherent by refreshing its held operand values each cycle.

## Interface
Parameters:
- `DATA_WIDTH`, 32, operand/result width
- `OPCODE_LENGTH`, 4, ALU operation code width
- `REG_ADDR_WIDTH`, 5, register index width

Ports:
- `clk`  in  1  clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `id_valid`  in  1  decode stage presents a real instruction
- `id_rs1`, `id_rs2`  in  REG_ADDR_WIDTH  source register indices
- `id_rd`  in  REG_ADDR_WIDTH  destination register index
- `id_rs1_data`, `id_rs2_data`  in  DATA_WIDTH  register file read data
- `id_imm`  in  DATA_WIDTH  sign-extended immediate
- `id_alu_src`  in  1  1 = `SrcB` takes the immediate, 0 = `SrcB` takes rs2
- `id_alu_op`  in  OPCODE_LENGTH  ALU operation code
- `id_reg_write`  in  1  instruction writes `rd`
- `stall`  in  1  hold the current EX instruction
- `flush`  in  1  replace the captured instruction with a bubble
- `mem_reg_write`, `mem_rd`, `mem_result`  in  1 / REG_ADDR_WIDTH / DATA_WIDTH  MEM-stage writeback candidate
- `wb_reg_write`, `wb_rd`, `wb_result`  in  1 / REG_ADDR_WIDTH / DATA_WIDTH  WB-stage writeback candidate
- `SrcA`  out  DATA_WIDTH  ALU operand A
- `SrcB`  out  DATA_WIDTH  ALU operand B
- `Operation`  out  OPCODE_LENGTH  ALU operation code
- `ex_valid`  out  1  EX holds a real instruction
- `ex_rd`  out  REG_ADDR_WIDTH  destination register of the EX instruction
- `ex_reg_write`  out  1  EX instruction writes `rd` (forced 0 when invalid)
- `ex_store_data`  out  DATA_WIDTH  forwarded rs2 value, for stores

## Operation
- **State.** Registered copies of: valid, rs1, rs2, rd, rs1_data, rs2_data, imm, alu_src, alu_op, reg_write.
- **Capture, per rising edge, in priority order:**
  1. `flush` → bubble: valid=0, reg_write=0, alu_op=0, data fields=0, indices=0.
  2. `stall` → all fields hold, except rs1_data/rs2_data, which are overwritten with the current forwarded values (fwdA/fwdB). This prevents loss of a WB value that retires during the stall.
  3. Otherwise → load all `id_*` fields.
- **Forwarding (combinational, from registered indices):**
  - fwdA = `mem_result` if `mem_reg_write` and `mem_rd` == rs1 and rs1 != 0.
  - Else fwdA = `wb_result` if `wb_reg_write` and `wb_rd` == rs1 and rs1 != 0.
  - Else fwdA = registered rs1_data.
  - fwdB is the same rule applied to rs2.
  - MEM has priority over WB. Register x0 is never forwarded.
- **Outputs:**
  - `SrcA` = fwdA.
  - `SrcB` = imm if alu_src, else fwdB.
  - `ex_store_data` = fwdB.
  - `Operation` = registered alu_op.
- **Bubble.** When valid=0, outputs are forced: `SrcA`=`SrcB`=0, `Operation`=4'b0000 (ADD), `ex_reg_write`=0, `ex_store_data`=0.
- **No arithmetic.** Data passes through at full `DATA_WIDTH`, with no width conversion.

## Timing
- **Reset.** Asynchronous, acting immediately. Every register clears to 0, so all outputs are 0: `SrcA`, `SrcB`, `Operation`=0, `ex_valid`=0, `ex_rd`=0, `ex_reg_write`=0, `ex_store_data`=0.
- **Reset mid-stall.** Reset overrides stall and flush; the held instruction is discarded.
- **Latency.** Inputs presented before edge N appear on the outputs after edge N: one cycle.
- **Forwarding timing.** Forwarding muxes are combinational in the same cycle. `mem_*`/`wb_*` changes reach `SrcA`/`SrcB` without a clock.
- **Simultaneous `stall` and `flush`.** Flush wins.
- **`id_valid`=0 without flush.** Captured as a bubble: valid=0 and reg_write is forced 0.
- **Stall length.** Unlimited. After the stall releases, the next edge loads the `id_*` fields.

## Test plan
- **Reset.** Assert `reset` asynchronously mid-cycle while valid data is held → all outputs read 0 before the next edge. After release, with `id_alu_op`=0001, rs1_data=5, rs2_data=3, alu_src=0 → after one edge, `SrcA`=5, `SrcB`=3, `Operation`=0001.
- **Forward priority.** EX rs1=x7; `mem_rd`=7 with `mem_result`=0xAA; `wb_rd`=7 with `wb_result`=0xBB; both write enables set → `SrcA`=0xAA. Drop `mem_reg_write` → `SrcA`=0xBB.
- **x0 guard.** rs2=0, `mem_rd`=0, `mem_reg_write`=1, `mem_result`=0x55, rs2_data=0, alu_src=0 → `SrcB`=0 and `ex_store_data`=0.
- **Immediate select.** alu_src=1, imm=0xFFFFFFFC, rs2 matches `mem_rd` with `mem_result`=9 → `SrcB`=0xFFFFFFFC and `ex_store_data`=9.
- **Stall retention.** Hold `stall` for 3 cycles. Cycle 1: `wb_rd`=rs1 with `wb_result`=0x1234. Cycle 2: WB no longer matches → `SrcA` stays 0x1234 through cycle 3, and the `id_*` changes during the stall are ignored.
- **Flush.** Assert `flush` and `stall` together with a valid ID instruction → after the edge, `ex_valid`=0, `ex_reg_write`=0, `Operation`=0000, `SrcA`=`SrcB`=0.
